// File: rtl/result_sel_seq.sv
// Registered execute-stage result selector. Single-cycle sources are captured on
// the request edge; multicycle sources run a start/done handshake with a timeout.
module result_sel_seq #(
    parameter int unsigned           WIDTH   = 32,
    parameter int unsigned           NUM_SRC = 6,
    parameter int unsigned           SEL_W   = 3,
    parameter logic [NUM_SRC-1:0]    MC_MASK = 6'b110000,
    parameter int unsigned           TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [SEL_W-1:0]           sel,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]         src_done,
    output logic [NUM_SRC-1:0]         src_start,
    output logic [WIDTH-1:0]           r_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // A zero TIMEOUT still needs a 1-bit timer so the counter logic elaborates.
    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [0:0]       state_q,     state_d;
    logic [SEL_W-1:0] sel_q,       sel_d;
    logic [TW-1:0]    timer_q,     timer_d;
    logic [WIDTH-1:0] r_out_q,     r_out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q,       err_d;

    logic             sel_hit;
    logic             sel_mc;
    logic [WIDTH-1:0] sel_data;
    logic             done_hit;
    logic [WIDTH-1:0] wait_data;

    // Decode the incoming sel and the captured sel_q against the real sources only,
    // so an out-of-range index simply fails to hit anything.
    always_comb begin
        sel_hit   = 1'b0;
        sel_mc    = 1'b0;
        sel_data  = '0;
        done_hit  = 1'b0;
        wait_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_hit  = 1'b1;
                sel_mc   = MC_MASK[i];
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
            if (sel_q == SEL_W'(i)) begin
                done_hit  = src_done[i];
                wait_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        src_start = '0;
        if (state_q == S_IDLE && req && sel_hit && sel_mc) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (sel == SEL_W'(i)) begin
                    src_start[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        r_out_d     = r_out_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!sel_hit) begin
                        err_d = 1'b1;
                    end else if (sel_mc) begin
                        sel_d   = sel;
                        timer_d = '0;
                        state_d = S_WAIT;
                    end else begin
                        r_out_d     = sel_data;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Done is checked before the timeout so a coincident done wins.
                if (done_hit) begin
                    r_out_d     = wait_data;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (TIMEOUT != 0 && timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            timer_q     <= '0;
            r_out_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            r_out_q     <= r_out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign r_out     = r_out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = (state_q == S_WAIT);

endmodule

// File: tb/tb_result_sel_seq.sv
// Directed bench for result_sel_seq: a default instance (TIMEOUT=64) and a short
// timeout instance (TIMEOUT=8) share stimulus; each is checked where it matters.
module tb_result_sel_seq;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned SEL_W   = 3;

    logic                     clk;
    logic                     rst;
    logic                     req;
    logic [SEL_W-1:0]         sel;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_done;

    logic [NUM_SRC-1:0] src_start_a, src_start_b;
    logic [WIDTH-1:0]   r_out_a,     r_out_b;
    logic               out_valid_a, out_valid_b;
    logic               busy_a,      busy_b;
    logic               err_a,       err_b;

    int checks;
    int failures;

    result_sel_seq #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W),
        .MC_MASK (6'b110000),
        .TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .src_data  (src_data),
        .src_done  (src_done),
        .src_start (src_start_a),
        .r_out     (r_out_a),
        .out_valid (out_valid_a),
        .busy      (busy_a),
        .err       (err_a)
    );

    result_sel_seq #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W),
        .MC_MASK (6'b110000),
        .TIMEOUT (8)
    ) dut_to (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .src_data  (src_data),
        .src_done  (src_done),
        .src_start (src_start_b),
        .r_out     (r_out_b),
        .out_valid (out_valid_b),
        .busy      (busy_b),
        .err       (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Outputs are inspected 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int unsigned idx, input logic [WIDTH-1:0] val);
        src_data[idx*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 1'b0;
        sel      = '0;
        src_data = '0;
        src_done = '0;

        // Reset
        step();
        step();
        check("rst_r_out",     64'(r_out_a),     64'h0);
        check("rst_out_valid", 64'(out_valid_a), 64'h0);
        check("rst_busy",      64'(busy_a),      64'h0);
        check("rst_err",       64'(err_a),       64'h0);
        check("rst_src_start", 64'(src_start_a), 64'h0);
        rst = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) set_src(i, 32'h1111_1111 * (i + 1));
        step();
        step();
        check("idle_r_out_hold", 64'(r_out_a), 64'h0);
        check("idle_no_valid",   64'(out_valid_a), 64'h0);

        // Single-cycle source
        set_src(2, 32'hDEAD_BEEF);
        sel = 3'd2;
        req = 1'b1;
        step();
        check("sc_r_out",     64'(r_out_a),     64'hDEAD_BEEF);
        check("sc_out_valid", 64'(out_valid_a), 64'h1);
        check("sc_busy",      64'(busy_a),      64'h0);
        set_src(0, 32'hA000_0000);
        set_src(1, 32'hA000_0001);
        set_src(3, 32'hA000_0003);
        sel = 3'd0; step();
        check("b2b0_data",  64'(r_out_a), 64'hA000_0000);
        check("b2b0_valid", 64'(out_valid_a), 64'h1);
        sel = 3'd1; step();
        check("b2b1_data",  64'(r_out_a), 64'hA000_0001);
        check("b2b1_valid", 64'(out_valid_a), 64'h1);
        sel = 3'd2; step();
        check("b2b2_data",  64'(r_out_a), 64'hDEAD_BEEF);
        check("b2b2_valid", 64'(out_valid_a), 64'h1);
        sel = 3'd3; step();
        check("b2b3_data",  64'(r_out_a), 64'hA000_0003);
        check("b2b3_valid", 64'(out_valid_a), 64'h1);
        req = 1'b0;
        step();
        check("sc_valid_drop", 64'(out_valid_a), 64'h0);

        // Multicycle source with a done handshake
        sel = 3'd4;
        req = 1'b1;
        #1;
        check("mc_start", 64'(src_start_a), 64'h10);
        step();
        check("mc_busy",     64'(busy_a),      64'h1);
        check("mc_no_valid", 64'(out_valid_a), 64'h0);
        sel = 3'd0;
        #1;
        check("mc_start_wait", 64'(src_start_a), 64'h0);
        for (int k = 0; k < 8; k++) step();
        src_done = 6'b100000;
        step();
        check("mc_other_done", 64'(busy_a),      64'h1);
        check("mc_hold_r_out", 64'(r_out_a),     64'hA000_0003);
        check("mc_wait_novld", 64'(out_valid_a), 64'h0);
        set_src(4, 32'h1234_5678);
        src_done = 6'b010000;
        req      = 1'b0;
        step();
        src_done = '0;
        check("mc_r_out",     64'(r_out_a),     64'h1234_5678);
        check("mc_out_valid", 64'(out_valid_a), 64'h1);
        check("mc_busy_done", 64'(busy_a),      64'h0);
        check("mc_err",       64'(err_a),       64'h0);

        // Bad sel
        sel = 3'd7;
        req = 1'b1;
        step();
        req = 1'b0;
        check("bad_err",   64'(err_a),       64'h1);
        check("bad_valid", 64'(out_valid_a), 64'h0);
        check("bad_r_out", 64'(r_out_a),     64'h1234_5678);
        check("bad_busy",  64'(busy_a),      64'h0);
        step();
        check("bad_err_pulse", 64'(err_a), 64'h0);

        // Timeout on the TIMEOUT=8 instance
        rst = 1'b1; step(); rst = 1'b0;
        sel = 3'd5;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check("to_busy", 64'(busy_b), 64'h1);
            check("to_noerr", 64'(err_b), 64'h0);
        end
        step();
        check("to_err",   64'(err_b),       64'h1);
        check("to_busy0", 64'(busy_b),      64'h0);
        check("to_novld", 64'(out_valid_b), 64'h0);
        check("to_r_out", 64'(r_out_b),     64'h0);
        set_src(5, 32'hAAAA_AAAA);
        src_done = 6'b100000;
        step();
        src_done = '0;
        check("late_done_valid", 64'(out_valid_b), 64'h0);
        check("late_done_err",   64'(err_b),       64'h0);
        check("late_done_r_out", 64'(r_out_b),     64'h0);
        check("late_done_busy",  64'(busy_b),      64'h0);

        sel = 3'd5;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("edge_busy", 64'(busy_b), 64'h1);
        set_src(5, 32'h55AA_55AA);
        src_done = 6'b100000;
        step();
        src_done = '0;
        check("edge_valid", 64'(out_valid_b), 64'h1);
        check("edge_err",   64'(err_b),       64'h0);
        check("edge_r_out", 64'(r_out_b),     64'h55AA_55AA);
        check("edge_busy0", 64'(busy_b),      64'h0);

        // Reset in the middle of WAIT
        rst = 1'b1; step(); rst = 1'b0;
        sel = 3'd4;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy",  64'(busy_a),      64'h0);
        check("mid_rst_valid", 64'(out_valid_a), 64'h0);
        check("mid_rst_err",   64'(err_a),       64'h0);
        set_src(1, 32'hCAFE_F00D);
        sel = 3'd1;
        req = 1'b1;
        step();
        req = 1'b0;
        check("post_rst_r_out", 64'(r_out_a),     64'hCAFE_F00D);
        check("post_rst_valid", 64'(out_valid_a), 64'h1);

        // Request accepted in the same cycle the multicycle result lands
        sel = 3'd4;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        set_src(4, 32'h0F0F_0F0F);
        src_done = 6'b010000;
        step();
        src_done = '0;
        check("turn_valid", 64'(out_valid_a), 64'h1);
        check("turn_r_out", 64'(r_out_a),     64'h0F0F_0F0F);
        sel = 3'd2;
        req = 1'b1;
        step();
        req = 1'b0;
        check("turn_next_valid", 64'(out_valid_a), 64'h1);
        check("turn_next_r_out", 64'(r_out_a),     64'hDEAD_BEEF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
